iobuf_turnaround_ctrl: RTL and testbench

IOBUF_TURNAROUND_CTRL -- requirements
Module: iobuf_turnaround_ctrl

---
 rtl/iobuf_turnaround_ctrl.sv | 139 +++++++++++++
 tb/tb_iobuf_turnaround_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/iobuf_turnaround_ctrl.sv
// Arbitrates one bidirectional pad bus between a write requester and a read sampler, with idle turnaround.
// Latency: write word on pad one cycle after acceptance; read sample on rd_data two cycles after pad capture.
// Backpressure: wr_ready only in WRITE; bursts are cut after MAX_BURST words only while the other side waits.
module iobuf_turnaround_ctrl #(
    parameter int WIDTH     = 8,
    parameter int TURN      = 2,
    parameter int MAX_BURST = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             wr_valid,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ready,
    input  logic             rd_req,
    output logic             rd_gnt,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] pad_o,
    output logic             pad_oe,
    input  logic [WIDTH-1:0] pad_i,
    output logic             busy
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int TW = (TURN > 1) ? $clog2(TURN) : 1;
    localparam logic [BW-1:0] BURST_MAX  = BW'(MAX_BURST);
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
    localparam logic [TW-1:0] TURN_LAST  = TW'(TURN - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_TURN  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             last_wr;      // 1: write was granted most recently, 0: read
    logic [BW-1:0]    burst_cnt;
    logic [TW-1:0]    turn_cnt;
    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic             smp1;
    logic [WIDTH-1:0] rd_hold;
    logic             wr_xfer;
    logic             rd_fire;
    logic             burst_last;

    assign wr_ready   = (state == S_WRITE);
    assign rd_gnt     = (state == S_READ);
    assign busy       = (state != S_IDLE);
    assign wr_xfer    = wr_ready & wr_valid;
    assign rd_fire    = rd_gnt & rd_req;
    // This word/sample is the MAX_BURST-th of the grant (or beyond, once saturated).
    assign burst_last = (burst_cnt >= BURST_LAST);
    // The second synchronizer flop feeds rd_data directly on a valid sample, otherwise the last sample is held.
    assign rd_data    = rd_valid ? sync2 : rd_hold;

    // Next-state arbitration: fair alternation on conflict, forced release only when the other side waits.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (wr_valid && rd_req) state_nxt = last_wr ? S_READ : S_WRITE;
                else if (wr_valid)      state_nxt = S_WRITE;
                else if (rd_req)        state_nxt = S_READ;
            end
            S_WRITE: begin
                if (!wr_valid)                 state_nxt = S_TURN;
                else if (rd_req && burst_last) state_nxt = S_TURN;
            end
            S_READ: begin
                if (!rd_req)                     state_nxt = S_TURN;
                else if (wr_valid && burst_last) state_nxt = S_TURN;
            end
            S_TURN: begin
                if (turn_cnt == TURN_LAST) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register and grant history.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            last_wr <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && state_nxt == S_WRITE) last_wr <= 1'b1;
            if (state == S_IDLE && state_nxt == S_READ)  last_wr <= 1'b0;
        end
    end

    // Burst counter held at zero in IDLE so every grant starts fresh; turnaround counter runs only in TURN.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            burst_cnt <= '0;
            turn_cnt  <= '0;
        end else begin
            if (state == S_IDLE)
                burst_cnt <= '0;
            else if ((wr_xfer || rd_fire) && burst_cnt != BURST_MAX)
                burst_cnt <= burst_cnt + BW'(1);
            if (state != S_TURN) turn_cnt <= '0;
            else                 turn_cnt <= turn_cnt + TW'(1);
        end
    end

    // Pad driver: a word is driven exactly in the cycle after its acceptance.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pad_oe <= 1'b0;
            pad_o  <= '0;
        end else begin
            pad_oe <= wr_xfer;
            if (wr_xfer) pad_o <= wr_data;
        end
    end

    // Pad synchronizer runs every cycle; sample-valid tracks it so in-flight samples survive leaving READ.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1    <= '0;
            sync2    <= '0;
            smp1     <= 1'b0;
            rd_valid <= 1'b0;
            rd_hold  <= '0;
        end else begin
            sync1    <= pad_i;
            sync2    <= sync1;
            smp1     <= rd_fire;
            rd_valid <= smp1;
            if (rd_valid) rd_hold <= sync2;
        end
    end

endmodule

// File: tb/tb_iobuf_turnaround_ctrl.sv
// Directed and randomized bench for iobuf_turnaround_ctrl with default parameters.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Prints one TB_RESULT summary line.
module tb_iobuf_turnaround_ctrl;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_ready;
    logic       rd_req = 1'b0;
    logic       rd_gnt;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic [7:0] pad_o;
    logic       pad_oe;
    logic [7:0] pad_i = 8'h00;
    logic       busy;

    int checks = 0;
    int failures = 0;

    iobuf_turnaround_ctrl #(.WIDTH(8), .TURN(2), .MAX_BURST(16)) dut (
        .clock(clock), .reset_n(reset_n),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_req(rd_req), .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
        .pad_o(pad_o), .pad_oe(pad_oe), .pad_i(pad_i), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 60) begin
            tick();
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_idle_timeout busy=%b exp=0", tag, busy);
        end
    endtask

    task automatic test_reset();
        wr_valid = 1'b1; rd_req = 1'b1; pad_i = 8'hFF; wr_data = 8'hEE;
        reset_n = 1'b0;
        tick(); tick();
        checks++; if (pad_oe !== 1'b0)   begin failures++; $display("FAIL rst_pad_oe got=%b exp=0", pad_oe); end
        checks++; if (pad_o !== 8'h00)   begin failures++; $display("FAIL rst_pad_o got=%h exp=00", pad_o); end
        checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL rst_wr_ready got=%b exp=0", wr_ready); end
        checks++; if (rd_gnt !== 1'b0)   begin failures++; $display("FAIL rst_rd_gnt got=%b exp=0", rd_gnt); end
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL rst_rd_valid got=%b exp=0", rd_valid); end
        checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL rst_rd_data got=%h exp=00", rd_data); end
        checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
        wr_valid = 1'b0; rd_req = 1'b0; pad_i = 8'h00;
        @(negedge clock);
        reset_n = 1'b1;
        tick();
    endtask

    // Both sides request right after reset: write wins, is cut after 16 words, then read follows.
    task automatic test_conflict();
        int words;
        wr_valid = 1'b1; rd_req = 1'b1; wr_data = 8'h00;
        words = 0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            wr_data = 8'(k);
            checks++; if (wr_ready !== 1'b1 || rd_gnt !== 1'b0) begin failures++; $display("FAIL cf_write_grant k=%0d wr_ready=%b rd_gnt=%b exp=1/0", k, wr_ready, rd_gnt); end
            if (wr_ready === 1'b1) words++;
        end
        tick(); // first TURN cycle
        checks++; if (wr_ready !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL cf_turn1 wr_ready=%b busy=%b exp=0/1 words=%0d", wr_ready, busy, words); end
        checks++; if (pad_oe !== 1'b1 || pad_o !== 8'h10) begin failures++; $display("FAIL cf_last_word pad_oe=%b pad_o=%h exp=1/10", pad_oe, pad_o); end
        tick(); // second TURN cycle
        checks++; if (pad_oe !== 1'b0 || rd_gnt !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL cf_turn2 pad_oe=%b rd_gnt=%b busy=%b exp=0/0/1", pad_oe, rd_gnt, busy); end
        tick(); // IDLE
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL cf_idle busy=%b exp=0", busy); end
        tick(); // READ
        checks++; if (rd_gnt !== 1'b1 || wr_ready !== 1'b0) begin failures++; $display("FAIL cf_read rd_gnt=%b wr_ready=%b exp=1/0", rd_gnt, wr_ready); end
        wr_valid = 1'b0; rd_req = 1'b0;
        wait_idle("cf");
    endtask

    task automatic test_write_burst();
        wr_valid = 1'b1; wr_data = 8'h11;
        tick(); // c1 WRITE
        checks++; if (wr_ready !== 1'b1 || pad_oe !== 1'b0) begin failures++; $display("FAIL wb_c1 wr_ready=%b pad_oe=%b exp=1/0", wr_ready, pad_oe); end
        tick(); wr_data = 8'h22; // c2
        checks++; if (pad_oe !== 1'b1 || pad_o !== 8'h11) begin failures++; $display("FAIL wb_w1 pad_oe=%b pad_o=%h exp=1/11", pad_oe, pad_o); end
        tick(); wr_data = 8'h33; // c3
        checks++; if (pad_oe !== 1'b1 || pad_o !== 8'h22) begin failures++; $display("FAIL wb_w2 pad_oe=%b pad_o=%h exp=1/22", pad_oe, pad_o); end
        tick(); wr_valid = 1'b0; // c4
        checks++; if (pad_oe !== 1'b1 || pad_o !== 8'h33) begin failures++; $display("FAIL wb_w3 pad_oe=%b pad_o=%h exp=1/33", pad_oe, pad_o); end
        tick(); // c5 TURN
        checks++; if (pad_oe !== 1'b0 || wr_ready !== 1'b0 || busy !== 1'b1 || pad_o !== 8'h33) begin failures++; $display("FAIL wb_turn1 pad_oe=%b wr_ready=%b busy=%b pad_o=%h exp=0/0/1/33", pad_oe, wr_ready, busy, pad_o); end
        tick(); // c6 TURN
        checks++; if (pad_oe !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL wb_turn2 pad_oe=%b busy=%b exp=0/1", pad_oe, busy); end
        tick(); // c7 IDLE
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wb_idle busy=%b exp=0", busy); end
    endtask

    // One sample in READ; it must emerge 2 cycles later even though READ has been left.
    task automatic test_read();
        rd_req = 1'b1; pad_i = 8'hA5;
        tick(); // r1 READ, sample taken
        checks++; if (rd_gnt !== 1'b1 || rd_valid !== 1'b0) begin failures++; $display("FAIL rd_r1 rd_gnt=%b rd_valid=%b exp=1/0", rd_gnt, rd_valid); end
        tick(); rd_req = 1'b0; pad_i = 8'h5A; // r2
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL rd_r2 rd_valid=%b exp=0", rd_valid); end
        tick(); // r3 TURN
        checks++; if (rd_valid !== 1'b1 || rd_data !== 8'hA5 || rd_gnt !== 1'b0) begin failures++; $display("FAIL rd_r3 rd_valid=%b rd_data=%h rd_gnt=%b exp=1/a5/0", rd_valid, rd_data, rd_gnt); end
        tick(); // r4
        checks++; if (rd_valid !== 1'b0 || rd_data !== 8'hA5) begin failures++; $display("FAIL rd_hold rd_valid=%b rd_data=%h exp=0/a5", rd_valid, rd_data); end
        wait_idle("rd");
    endtask

    task automatic test_turnaround();
        int gap;
        bit found;
        wr_valid = 1'b1; rd_req = 1'b1; wr_data = 8'h5C;
        tick(); // WRITE, one transfer
        checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL ta_write wr_ready=%b exp=1", wr_ready); end
        tick();
        wr_valid = 1'b0;
        checks++; if (pad_oe !== 1'b1 || pad_o !== 8'h5C) begin failures++; $display("FAIL ta_pad pad_oe=%b pad_o=%h exp=1/5c", pad_oe, pad_o); end
        gap = 0; found = 1'b0;
        for (int n = 0; n < 30 && !found; n++) begin
            tick();
            if (rd_gnt === 1'b1) found = 1'b1;
            else if (pad_oe === 1'b1) gap = 0;
            else gap++;
        end
        checks++; if (!found || gap != 3) begin failures++; $display("FAIL ta_gap found=%b gap=%0d exp=1/3", found, gap); end
        rd_req = 1'b0;
        wait_idle("ta");
    endtask

    task automatic test_reset_mid_write();
        wr_valid = 1'b1; wr_data = 8'h77;
        tick(); tick();
        checks++; if (pad_oe !== 1'b1) begin failures++; $display("FAIL rm_pre pad_oe=%b exp=1", pad_oe); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (pad_oe !== 1'b0 || pad_o !== 8'h00 || busy !== 1'b0 || wr_ready !== 1'b0) begin failures++; $display("FAIL rm_async pad_oe=%b pad_o=%h busy=%b wr_ready=%b exp=0/00/0/0", pad_oe, pad_o, busy, wr_ready); end
        wr_valid = 1'b0; rd_req = 1'b1;
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        checks++; if (rd_gnt !== 1'b1 || pad_oe !== 1'b0) begin failures++; $display("FAIL rm_read rd_gnt=%b pad_oe=%b exp=1/0", rd_gnt, pad_oe); end
        rd_req = 1'b0;
        wait_idle("rm");
    endtask

    task automatic test_stress();
        bit prev_xfer;
        int streak_w, streak_r, max_w, max_r, bad;
        prev_xfer = 1'b0; streak_w = 0; streak_r = 0; max_w = 0; max_r = 0; bad = 0;
        for (int n = 0; n < 10000; n++) begin
            tick();
            checks++; if ((pad_oe & rd_gnt) !== 1'b0) begin failures++; bad++; if (bad < 10) $display("FAIL st_oe_gnt cyc=%0d pad_oe=%b rd_gnt=%b exp=not both", n, pad_oe, rd_gnt); end
            checks++; if (pad_oe !== prev_xfer) begin failures++; bad++; if (bad < 10) $display("FAIL st_oe_follow cyc=%0d pad_oe=%b exp=%b", n, pad_oe, prev_xfer); end
            if ($urandom_range(7) == 0) wr_valid = ~wr_valid;
            if ($urandom_range(7) == 0) rd_req = ~rd_req;
            wr_data = 8'($urandom_range(255));
            pad_i = 8'($urandom_range(255));
            prev_xfer = wr_valid & wr_ready;
            if (wr_valid && wr_ready && rd_req) streak_w++;
            else streak_w = 0;
            if (rd_req && rd_gnt && wr_valid) streak_r++;
            else streak_r = 0;
            if (streak_w > max_w) max_w = streak_w;
            if (streak_r > max_r) max_r = streak_r;
        end
        checks++; if (max_w > 16) begin failures++; $display("FAIL st_write_burst max=%0d exp<=16", max_w); end
        checks++; if (max_r > 16) begin failures++; $display("FAIL st_read_burst max=%0d exp<=16", max_r); end
        wr_valid = 1'b0; rd_req = 1'b0;
        wait_idle("st");
    endtask

    initial begin
        test_reset();
        test_conflict();
        test_write_burst();
        test_read();
        test_turnaround();
        test_reset_mid_write();
        test_stress();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
